// File: rtl/lgn_pkg.sv
// Shared constants and FSM state encoding for the LGN classifier host-side streamer.
package lgn_pkg;
  localparam int INPUTS     = 256;
  localparam int BYTE_W     = 8;
  localparam int N_BYTES    = INPUTS / BYTE_W;
  localparam int CATEGORIES = 10;
  localparam int IDX_W      = 4;
  localparam int VAL_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    RESULT = 2'd3
  } state_e;
endpackage

// File: rtl/lgn_byte_serializer.sv
// Holds one image and presents it MSB byte first, one byte per shift; flags the final byte.
module lgn_byte_serializer
  import lgn_pkg::*;
#(
  parameter int W_BITS = INPUTS,
  parameter int W_BYTE = BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [W_BITS-1:0] data_i,
  output logic [W_BYTE-1:0] byte_o,
  output logic              last_o
);
  localparam int NB = W_BITS / W_BYTE;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  logic [W_BITS-1:0] sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      sreg_d = data_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      sreg_d = sreg_q << W_BYTE;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byte_o = sreg_q[W_BITS-1 -: W_BYTE];
  assign last_o = (cnt_q == CNT_LAST);
endmodule

// File: rtl/lgn_frame_streamer.sv
// Streams one binarised image into the classifier byte bus, waits to settle, and returns argmax.
module lgn_frame_streamer
  import lgn_pkg::state_e, lgn_pkg::IDLE, lgn_pkg::SHIFT, lgn_pkg::SETTLE, lgn_pkg::RESULT;
#(
  parameter int INPUTS        = lgn_pkg::INPUTS,
  parameter int BYTE_W        = lgn_pkg::BYTE_W,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDX_W         = lgn_pkg::IDX_W,
  parameter int VAL_W         = lgn_pkg::VAL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              img_valid,
  output logic              img_ready,
  input  logic [INPUTS-1:0] img_data,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_we,
  input  logic [IDX_W-1:0]  res_index,
  input  logic [VAL_W-1:0]  res_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [VAL_W-1:0]  out_value,
  output logic              busy
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  val_q, val_d;
  logic              load, shift_en, last;
  logic [BYTE_W-1:0] top_byte;

  assign img_ready = (state_q == IDLE);
  assign load      = img_valid && img_ready;
  assign shift_en  = (state_q == SHIFT);

  lgn_byte_serializer #(.W_BITS(INPUTS), .W_BYTE(BYTE_W)) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .shift_i(shift_en),
    .data_i (img_data),
    .byte_o (top_byte),
    .last_o (last)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    val_d    = val_q;
    case (state_q)
      IDLE:   if (img_valid) state_d = SHIFT;
      SHIFT:  if (last) begin
                state_d  = SETTLE;
                settle_d = '0;
              end
      // Result pins are sampled only on the final settle edge.
      SETTLE: if (settle_q == SETTLE_LAST) begin
                state_d = RESULT;
                idx_d   = res_index;
                val_d   = res_value;
              end else begin
                settle_d = settle_q + 1'b1;
              end
      RESULT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      idx_q    <= '0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
    end
  end

  assign byte_we   = shift_en;
  assign byte_out  = shift_en ? top_byte : '0;
  assign out_valid = (state_q == RESULT);
  assign out_index = idx_q;
  assign out_value = val_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_lgn_frame_streamer.sv
// Directed + randomised checks of the frame streamer against a receiver/timing reference model.
module tb_lgn_frame_streamer;
  localparam int NB = 32;
  localparam int SC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, img_valid, img_ready, byte_we, out_valid, out_ready, busy;
  logic [255:0] img_data;
  logic [7:0]   byte_out, res_value, out_value;
  logic [3:0]   res_index, out_index;

  logic         img_valid1, img_ready1, byte_we1, out_valid1, out_ready1, busy1;
  logic [255:0] img_data1;
  logic [7:0]   byte_out1, res_value1, out_value1;
  logic [3:0]   res_index1, out_index1;

  lgn_frame_streamer #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
    .byte_out(byte_out), .byte_we(byte_we), .res_index(res_index), .res_value(res_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_value(out_value),
    .busy(busy)
  );

  lgn_frame_streamer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .img_valid(img_valid1), .img_ready(img_ready1), .img_data(img_data1),
    .byte_out(byte_out1), .byte_we(byte_we1), .res_index(res_index1), .res_value(res_value1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_index(out_index1), .out_value(out_value1),
    .busy(busy1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_q[$];
  logic [255:0] rx = '0;

  // Receiver model: shift left, insert at LSB, only on byte_we. Accept log for timing.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (byte_we) rx <= {rx[247:0], byte_out};
    if (!rst && img_valid && img_ready) acc_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [255:0] img, input int k);
    return img[255 - 8*k -: 8];
  endfunction

  // One frame on the default instance; hold keeps img_valid high with alt data afterwards.
  task automatic frame(input logic [255:0] img, input logic [3:0] idx, input logic [7:0] val,
                       input int bp, input bit hold, input logic [255:0] alt);
    int n0;
    n0 = acc_q.size();
    chk("idle_ready", img_ready, 1);
    img_valid = 1; img_data = img; res_index = idx; res_value = val; out_ready = (bp == 0);
    tick();
    chk("accept", acc_q.size() - n0, 1);
    if (hold) img_data = alt; else img_valid = 0;
    for (int k = 0; k < NB; k++) begin
      chk("shift_we", byte_we, 1);
      chk("shift_byte", byte_out, exp_byte(img, k));
      chk("shift_ready", img_ready, 0);
      chk("shift_busy", busy, 1);
      tick();
    end
    for (int s = 0; s < SC; s++) begin
      chk("settle_we", byte_we, 0);
      chk("settle_byte", byte_out, 0);
      chk("settle_ov", out_valid, 0);
      tick();
    end
    chk("res_valid", out_valid, 1);
    chk("res_index", out_index, idx);
    chk("res_value", out_value, val);
    chk("rx_image", rx, img);
    for (int b = 0; b < bp; b++) begin
      res_index = 4'($urandom); res_value = 8'($urandom);
      chk("bp_valid", out_valid, 1);
      chk("bp_index", out_index, idx);
      chk("bp_value", out_value, val);
      chk("bp_ready", img_ready, 0);
      tick();
    end
    out_ready = 1;
    chk("hs_valid", out_valid, 1);
    tick();
    chk("post_ov", out_valid, 0);
    chk("post_ready", img_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_index", out_index, idx);
    chk("post_value", out_value, val);
    chk("one_accept", acc_q.size() - n0, 1);
  endtask

  initial begin
    logic [255:0] ramp, a, b;
    logic [3:0]   cap_i;
    logic [7:0]   cap_v;
    int           n;

    rst = 1; img_valid = 0; img_data = '0; res_index = '0; res_value = '0; out_ready = 0;
    img_valid1 = 0; img_data1 = '0; res_index1 = '0; res_value1 = '0; out_ready1 = 0;
    tick(); tick();
    chk("rst_ready", img_ready, 1);
    chk("rst_we", byte_we, 0);
    chk("rst_byte", byte_out, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_idx", out_index, 0);
    chk("rst_val", out_value, 0);
    chk("rst_busy", busy, 0);
    chk("rst1_busy", busy1, 0);

    // Reset and a valid image on the same edge: reset wins.
    img_valid = 1; img_data = rnd256();
    tick();
    rst = 0; img_valid = 0;
    chk("rstwin_busy", busy, 0);
    chk("rstwin_we", byte_we, 0);
    chk("rstwin_ready", img_ready, 1);

    for (int k = 0; k < NB; k++) ramp[255 - 8*k -: 8] = 8'(k);
    frame(ramp, 4'd7, 8'd143, 0, 1'b0, '0);

    frame(rnd256(), 4'($urandom), 8'($urandom), 20, 1'b0, '0);

    a = rnd256();
    frame(a, 4'($urandom), 8'($urandom), 0, 1'b1, ~a);
    img_valid = 0;

    a = rnd256(); b = rnd256();
    frame(a, 4'($urandom), 8'($urandom), 0, 1'b1, b);
    frame(b, 4'($urandom), 8'($urandom), 0, 1'b0, '0);
    n = acc_q.size();
    chk("b2b_period", acc_q[n-1] - acc_q[n-2], NB + SC + 2);

    // Reset while byte 10 is on the bus.
    img_valid = 1; img_data = rnd256();
    tick();
    img_valid = 0;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_we_before", byte_we, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_we", byte_we, 0);
    chk("mid_ready", img_ready, 1);
    chk("mid_ov", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_idx", out_index, 0);
    frame(rnd256(), 4'($urandom), 8'($urandom), 0, 1'b0, '0);
    chk("accept_total", acc_q.size(), 7);

    // Single-cycle settle instance: only the capture-edge result may appear.
    cap_i = 4'($urandom); cap_v = 8'($urandom);
    a = rnd256();
    img_valid1 = 1; img_data1 = a; out_ready1 = 1;
    tick();
    img_valid1 = 0;
    for (int c = 1; c <= NB + 1; c++) begin
      if (c == NB + 1) begin
        res_index1 = cap_i; res_value1 = cap_v;
        chk("s1_we_settle", byte_we1, 0);
        chk("s1_ov_settle", out_valid1, 0);
      end else begin
        res_index1 = cap_i + 4'(1 + $urandom_range(0, 14));
        res_value1 = cap_v + 8'(1 + $urandom_range(0, 254));
        chk("s1_we", byte_we1, 1);
        chk("s1_byte", byte_out1, exp_byte(a, c - 1));
      end
      tick();
    end
    res_index1 = ~cap_i; res_value1 = ~cap_v;
    chk("s1_ov", out_valid1, 1);
    chk("s1_idx", out_index1, cap_i);
    chk("s1_val", out_value1, cap_v);
    tick();
    chk("s1_ready", img_ready1, 1);
    chk("s1_ov_done", out_valid1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
